// File: rtl/qlab5_nios2_qsys_0_oci_dct_packer.sv
// Packs a stream of 2-bit data-trace codes into 30-bit frames of up to 15 codes
// and hands each frame downstream with its code count over valid/ready.
module qlab5_nios2_qsys_0_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [1:0]  code,
  output logic        code_ready,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        idle
);

  logic [29:0] acc_buf;
  logic [3:0]  acc_cnt;
  logic        flush_pend;
  logic        flush_pend_n;
  logic        slot_free;
  logic        acc_full;
  logic        accept;
  logic        xfer;

  assign slot_free  = !frame_valid || frame_ready;
  assign acc_full   = (acc_cnt == 4'd15);
  assign code_ready = !acc_full || slot_free;
  assign accept     = code_valid && code_ready;
  assign xfer       = slot_free && (acc_full || (flush_pend && (acc_cnt != 4'd0)));
  assign idle       = (acc_cnt == 4'd0) && !frame_valid && !flush_pend;

  // A new flush request wins over the clear, so a code accepted alongside it
  // is still flushed even when the previous frame leaves on the same edge.
  always_comb begin
    flush_pend_n = flush_pend;
    if (xfer || ((acc_cnt == 4'd0) && !accept))
      flush_pend_n = 1'b0;
    if (flush)
      flush_pend_n = 1'b1;
  end

  // Stage 0: accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_buf    <= '0;
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush_pend_n;
      if (xfer) begin
        acc_buf <= accept ? {28'b0, code} : 30'b0;
        acc_cnt <= accept ? 4'd1 : 4'd0;
      end else if (accept) begin
        acc_buf <= {acc_buf[27:0], code};
        acc_cnt <= acc_cnt + 4'd1;
      end
    end
  end

  // Stage 1: output holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer  <= '0;
      dct_count   <= '0;
      frame_valid <= 1'b0;
    end else if (xfer) begin
      dct_buffer  <= acc_buf;
      dct_count   <= acc_cnt;
      frame_valid <= 1'b1;
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule
